// File: rtl/g_function_inv.sv
// ---------------------------------------------------------------------------
// g_function_inv
//
// Purpose:
//   Pipelined inverse of the BLAKE2s/BLAKE3 G mixing function. Given a
//   post-mix state (A',B',C',D') and the same message words X, Y that the
//   forward G consumed, it recovers the pre-mix state (A,B,C,D). The forward
//   quarter-round is unwound in four registered steps, one per pipeline stage.
//
// Ports:
//   Clk      in   clock, all state updates on the rising edge
//   Rst_n    in   asynchronous active-low reset
//   Valid_I  in   input state valid
//   Ready_O  out  block can accept an input this cycle
//   A_I..D_I in   post-mix words A', B', C', D'
//   X_I      in   first message word
//   Y_I      in   second message word
//   Valid_O  out  recovered state valid
//   Ready_I  in   downstream accepts the output
//   A_O..D_O out  recovered words A, B, C, D
// ---------------------------------------------------------------------------
module g_function_inv (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Valid_I,
    output logic        Ready_O,
    input  logic [31:0] A_I,
    input  logic [31:0] B_I,
    input  logic [31:0] C_I,
    input  logic [31:0] D_I,
    input  logic [31:0] X_I,
    input  logic [31:0] Y_I,
    output logic        Valid_O,
    input  logic        Ready_I,
    output logic [31:0] A_O,
    output logic [31:0] B_O,
    output logic [31:0] C_O,
    output logic [31:0] D_O
);

    localparam int LATENCY = 4;
    localparam int WORD_W  = 32;

    // Stage 1 state
    logic [WORD_W-1:0] s1B1_q, s1C1_q, s1A_q, s1D_q, s1X_q, s1Y_q;
    logic [WORD_W-1:0] s1B1_d, s1C1_d;
    // Stage 2 state
    logic [WORD_W-1:0] s2D1_q, s2A1_q, s2B1_q, s2C1_q, s2X_q;
    logic [WORD_W-1:0] s2D1_d, s2A1_d;
    // Stage 3 state
    logic [WORD_W-1:0] s3B0_q, s3C0_q, s3A1_q, s3D1_q, s3X_q;
    logic [WORD_W-1:0] s3B0_d, s3C0_d;
    // Stage 4 (output) state
    logic [WORD_W-1:0] s4A0_q, s4B0_q, s4C0_q, s4D0_q;
    logic [WORD_W-1:0] s4A0_d, s4D0_d;

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;
    logic               adv;

    // One global advance signal: the whole pipe moves or the whole pipe
    // holds, so bubbles are kept rather than collapsed. This keeps the
    // ready path a single gate deep at the cost of some stall efficiency.
    assign adv     = !valid_q[LATENCY-1] || Ready_I;
    assign Ready_O = adv;

    // Each step undoes one half of the forward quarter-round in reverse
    // order; the rotate-lefts invert the forward rotate-rights 7/8/12/16.
    always_comb begin
        s1B1_d  = {B_I[24:0], B_I[31:25]} ^ C_I;
        s1C1_d  = C_I - D_I;

        s2D1_d  = {s1D_q[23:0], s1D_q[31:24]} ^ s1A_q;
        s2A1_d  = s1A_q - s1B1_q - s1Y_q;

        s3B0_d  = {s2B1_q[19:0], s2B1_q[31:20]} ^ s2C1_q;
        s3C0_d  = s2C1_q - s2D1_q;

        s4D0_d  = {s3D1_q[15:0], s3D1_q[31:16]} ^ s3A1_q;
        s4A0_d  = s3A1_q - s3B0_q - s3X_q;

        valid_d = {valid_q[LATENCY-2:0], Valid_I};
    end

    // Data registers load whenever the pipe advances, independent of the
    // valid bits; only the valid bits decide what the outside world sees.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= '0;
            s1B1_q  <= '0;
            s1C1_q  <= '0;
            s1A_q   <= '0;
            s1D_q   <= '0;
            s1X_q   <= '0;
            s1Y_q   <= '0;
            s2D1_q  <= '0;
            s2A1_q  <= '0;
            s2B1_q  <= '0;
            s2C1_q  <= '0;
            s2X_q   <= '0;
            s3B0_q  <= '0;
            s3C0_q  <= '0;
            s3A1_q  <= '0;
            s3D1_q  <= '0;
            s3X_q   <= '0;
            s4A0_q  <= '0;
            s4B0_q  <= '0;
            s4C0_q  <= '0;
            s4D0_q  <= '0;
        end else if (adv) begin
            valid_q <= valid_d;

            s1B1_q  <= s1B1_d;
            s1C1_q  <= s1C1_d;
            s1A_q   <= A_I;
            s1D_q   <= D_I;
            s1X_q   <= X_I;
            s1Y_q   <= Y_I;

            s2D1_q  <= s2D1_d;
            s2A1_q  <= s2A1_d;
            s2B1_q  <= s1B1_q;
            s2C1_q  <= s1C1_q;
            s2X_q   <= s1X_q;

            s3B0_q  <= s3B0_d;
            s3C0_q  <= s3C0_d;
            s3A1_q  <= s2A1_q;
            s3D1_q  <= s2D1_q;
            s3X_q   <= s2X_q;

            s4A0_q  <= s4A0_d;
            s4B0_q  <= s3B0_q;
            s4C0_q  <= s3C0_q;
            s4D0_q  <= s4D0_d;
        end
    end

    assign Valid_O = valid_q[LATENCY-1];
    assign A_O     = s4A0_q;
    assign B_O     = s4B0_q;
    assign C_O     = s4C0_q;
    assign D_O     = s4D0_q;

endmodule
